// File: rtl/hwpe_ctrl_uloop_dispatch.sv
// hwpe_ctrl_uloop_dispatch
// Steps an external uloop one iteration at a time. For each iteration it
// turns the uloop's per-stream offsets into absolute streamer addresses
// and issues them as a single command.
//
// Command handshake: a command transfers on a rising clk_i edge where
// cmd_valid_o and cmd_ready_i are both high. Once cmd_valid_o rises, it stays
// high until that transfer happens. cmd_addr_o, cmd_idx_o and cmd_last_o come
// straight from registers, so they cannot change while a command waits.
// The only way to withdraw a pending command is clear_i or rst_ni.
//
// The state_q enum is the FSM debug view. IDLE is encoded as zero.
module hwpe_ctrl_uloop_dispatch #(
    parameter int NB_STREAMS = 4,
    parameter int NB_LOOPS   = 6,
    parameter int REG_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             start_i,
    input  logic [NB_STREAMS*REG_WIDTH-1:0]  base_addr_i,
    output logic                             uloop_enable_o,
    output logic                             uloop_clear_o,
    input  logic                             uloop_valid_i,
    input  logic                             uloop_done_i,
    input  logic [NB_STREAMS*REG_WIDTH-1:0]  uloop_offs_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]    uloop_idx_i,
    output logic                             cmd_valid_o,
    input  logic                             cmd_ready_i,
    output logic [NB_STREAMS*REG_WIDTH-1:0]  cmd_addr_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]    cmd_idx_o,
    output logic                             cmd_last_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [CNT_WIDTH-1:0]             iter_cnt_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        FINISH = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [NB_STREAMS*REG_WIDTH-1:0] base_q;
    logic [NB_STREAMS*REG_WIDTH-1:0] addr_q;
    logic [NB_LOOPS*CNT_WIDTH-1:0]   idx_q;
    logic                            last_q;
    logic [CNT_WIDTH-1:0]            cnt_q;

    // Qualified events. Each one only counts in its own state, so stray
    // start_i or uloop_valid_i pulses in other states have no effect.
    logic start_ok;
    logic flags_ok;
    logic hs_ok;

    assign start_ok = (state_q == IDLE)  && start_i;
    assign flags_ok = (state_q == WAIT)  && uloop_valid_i;
    assign hs_ok    = (state_q == ISSUE) && cmd_ready_i;

    // State register: asynchronous reset to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The clear_i override is applied last so it always
    // wins, including over a handshake completing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)       state_d = STEP;
            STEP:                       state_d = WAIT;
            WAIT:    if (uloop_valid_i) state_d = ISSUE;
            ISSUE:   if (cmd_ready_i)   state_d = last_q ? FINISH : STEP;
            FINISH:                     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    // Job datapath. Latches the bases at start, computes the per-stream sums
    // when the uloop flags arrive, and counts accepted commands.
    // Each stream is added on its own, so a carry never crosses a stream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            addr_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            base_q <= '0;
            addr_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (start_ok) begin
                base_q <= base_addr_i;
                cnt_q  <= '0;
            end
            if (flags_ok) begin
                for (int s = 0; s < NB_STREAMS; s++) begin
                    addr_q[s*REG_WIDTH +: REG_WIDTH] <=
                        base_q[s*REG_WIDTH +: REG_WIDTH] + uloop_offs_i[s*REG_WIDTH +: REG_WIDTH];
                end
                idx_q  <= uloop_idx_i;
                last_q <= uloop_done_i;
            end
            if (hs_ok) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output decode from the current state.
    // uloop_clear_o also follows clear_i and an accepted start in the same
    // cycle. It is held low while rst_ni is asserted.
    always_comb begin
        uloop_enable_o = (state_q == STEP);
        cmd_valid_o    = (state_q == ISSUE);
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == FINISH);
        uloop_clear_o  = rst_ni & (clear_i | start_ok | (state_q == FINISH));
        cmd_addr_o     = addr_q;
        cmd_idx_o      = idx_q;
        cmd_last_o     = last_q;
        iter_cnt_o     = cnt_q;
    end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_dispatch.sv
// Testbench for hwpe_ctrl_uloop_dispatch.
// The bench steps in lockstep with the DUT and plays the role of the uloop.
// A reference model computes each expected command address from the job's
// bases and offsets. Those expected addresses wait in exp_q until the
// command is accepted.
module tb_hwpe_ctrl_uloop_dispatch;

  localparam int NB = 4;
  localparam int NL = 6;
  localparam int RW = 32;
  localparam int CW = 16;
  localparam int AW = NB * RW;
  localparam int IW = NL * CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          uloop_enable_o;
  logic          uloop_clear_o;
  logic          uloop_valid_i = 1'b0;
  logic          uloop_done_i = 1'b0;
  logic [AW-1:0] uloop_offs_i = '0;
  logic [IW-1:0] uloop_idx_i = '0;
  logic          cmd_valid_o;
  logic          cmd_ready_i = 1'b0;
  logic [AW-1:0] cmd_addr_o;
  logic [IW-1:0] cmd_idx_o;
  logic          cmd_last_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] iter_cnt_o;

  hwpe_ctrl_uloop_dispatch #(
    .NB_STREAMS(NB), .NB_LOOPS(NL), .REG_WIDTH(RW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .uloop_enable_o(uloop_enable_o),
    .uloop_clear_o(uloop_clear_o), .uloop_valid_i(uloop_valid_i),
    .uloop_done_i(uloop_done_i), .uloop_offs_i(uloop_offs_i),
    .uloop_idx_i(uloop_idx_i), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .cmd_addr_o(cmd_addr_o), .cmd_idx_o(cmd_idx_o),
    .cmd_last_o(cmd_last_o), .busy_o(busy_o), .done_o(done_o),
    .iter_cnt_o(iter_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] cur_base;
  logic [AW-1:0] it_offs[16];
  logic [IW-1:0] it_idx[16];
  logic [IW-1:0] exp_idx;
  logic          exp_last;
  int            exp_cnt;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: each stream's address is its base plus its offset,
  // wrapped to 32 bits independently.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input logic [AW-1:0] o);
    logic [AW-1:0] r;
    logic [RW-1:0] bs, os;
    for (int s = 0; s < NB; s++) begin
      bs = b[s*RW +: RW];
      os = o[s*RW +: RW];
      r[s*RW +: RW] = bs + os;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] outs_flat();
    return {uloop_enable_o, uloop_clear_o, cmd_valid_o, cmd_last_o, busy_o, done_o,
            iter_cnt_o, cmd_idx_o == '0, cmd_addr_o == '0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [AW-1:0] base);
    cur_base    = base;
    exp_cnt     = 0;
    base_addr_i = base;
    start_i     = 1'b1;
    #1;
    check("start_clr", uloop_clear_o, 1);
    check("start_idle", busy_o, 0);
    tick();
    start_i     = 1'b0;
    base_addr_i = rand_wide();
    check("start_cnt0", iter_cnt_o, 0);
  endtask

  // Entered in STEP. Plays the uloop and returns with the DUT in ISSUE.
  task automatic fetch(input int it, input int n, input int lat, input bit poke);
    check("step_en", uloop_enable_o, 1);
    check("step_nv", cmd_valid_o, 0);
    tick();
    for (int l = 0; l < lat; l++) begin
      check("wait_en", uloop_enable_o, 0);
      check("wait_nv", cmd_valid_o, 0);
      if (poke && l == 0) start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
    uloop_offs_i  = it_offs[it];
    uloop_idx_i   = it_idx[it];
    uloop_done_i  = (it == n - 1);
    uloop_valid_i = 1'b1;
    exp_q.push_back(model_addr(cur_base, it_offs[it]));
    exp_idx  = it_idx[it];
    exp_last = (it == n - 1);
    tick();
    uloop_valid_i = 1'b0;
    uloop_done_i  = 1'($urandom_range(0, 1));
    uloop_offs_i  = rand_wide();
    check("issue_v", cmd_valid_o, 1);
    check("issue_addr", cmd_addr_o, exp_q[0]);
    check("issue_idx", cmd_idx_o, exp_idx);
    check("issue_last", cmd_last_o, exp_last);
    check("issue_nodone", done_o, 0);
  endtask

  // Holds the command under backpressure for bp cycles, then accepts it.
  task automatic handshake(input int bp);
    for (int b = 0; b < bp; b++) begin
      cmd_ready_i   = 1'b0;
      uloop_valid_i = 1'($urandom_range(0, 1));
      tick();
      check("bp_valid", cmd_valid_o, 1);
      check("bp_addr", cmd_addr_o, exp_q[0]);
      check("bp_last", cmd_last_o, exp_last);
      check("bp_en", uloop_enable_o, 0);
      check("bp_cnt", iter_cnt_o, exp_cnt);
    end
    uloop_valid_i = 1'b0;
    cmd_ready_i   = 1'b1;
    tick();
    cmd_ready_i   = 1'b0;
    void'(exp_q.pop_front());
    exp_cnt++;
    check("hs_cnt", iter_cnt_o, exp_cnt);
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int n, input int bp0, input int poke_it);
    int lat;
    start_job(base);
    for (int it = 0; it < n; it++) begin
      lat = $urandom_range(0, 3);
      if (it == poke_it && lat == 0) lat = 1;
      fetch(it, n, lat, it == poke_it);
      handshake(it == 0 ? bp0 : $urandom_range(0, 2));
    end
    check("fin_done", done_o, 1);
    check("fin_clr", uloop_clear_o, 1);
    check("fin_busy", busy_o, 1);
    tick();
    check("end_busy", busy_o, 0);
    check("end_done", done_o, 0);
    check("end_cnt", iter_cnt_o, n);
  endtask

  task automatic rand_iters(input int n);
    for (int i = 0; i < n; i++) begin
      it_offs[i] = rand_wide();
      it_idx[i]  = {$urandom, $urandom, $urandom};
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_outs", outs_flat(), {6'b0, 16'b0, 1'b1, 1'b1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // Basic two-iteration job, with 5 cycles of backpressure on the first command
    it_offs[0] = {32'h0, 32'h0, 32'd8, 32'd4};
    it_offs[1] = {32'h0, 32'h0, 32'd16, 32'd8};
    it_idx[0]  = {{(IW-CW){1'b0}}, 16'd0};
    it_idx[1]  = {{(IW-CW){1'b0}}, 16'd1};
    run_job({32'h0, 32'h0, 32'h2000, 32'h1000}, 2, 5, -1);

    // Wrap per stream, no carry between streams, single-iteration job with done set
    it_offs[0] = {32'h0, 32'h0, 32'h1, 32'h20};
    it_idx[0]  = '0;
    run_job({32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF0}, 1, 0, -1);

    // start_i pulsed while waiting for uloop flags
    rand_iters(3);
    run_job(rand_wide(), 3, 1, 1);

    // Clear while a handshake completes
    rand_iters(3);
    start_job(rand_wide());
    fetch(0, 3, 1, 1'b0);
    cmd_ready_i = 1'b1;
    clear_i     = 1'b1;
    #1;
    check("clr_comb", uloop_clear_o, 1);
    tick();
    clear_i     = 1'b0;
    cmd_ready_i = 1'b0;
    exp_q.delete();
    check("clr_busy", busy_o, 0);
    check("clr_valid", cmd_valid_o, 0);
    check("clr_cnt", iter_cnt_o, 0);
    check("clr_addr", cmd_addr_o, 0);
    check("clr_done", done_o, 0);
    tick();
    check("clr_done2", done_o, 0);

    // Async reset while waiting, then a full job
    rand_iters(2);
    start_job(rand_wide());
    check("pre_rst_en", uloop_enable_o, 1);
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_outs", outs_flat(), {6'b0, 16'b0, 1'b1, 1'b1});
    tick();
    check("arst_done", done_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    check("post_rst_busy", busy_o, 0);
    rand_iters(2);
    run_job(rand_wide(), 2, 2, -1);

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 5);
      rand_iters(n);
      run_job(rand_wide(), n, $urandom_range(0, 3),
              $urandom_range(0, 1) ? $urandom_range(0, n - 1) : -1);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
